// File: rtl/vixen_cache_level_model.sv
// Behavioural stand-in for one cache level: round-robin arbitration over the upstream ports,
// one transaction in flight, fixed-latency echo hits (MODE=0) or forwarding to the next level (MODE=1).
module vixen_cache_level_model #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 64,
    parameter int LINE_W      = 512,
    parameter int HIT_LATENCY = 10,
    parameter int MODE        = 0,
    parameter int CNT_W       = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [LINE_W-1:0]           rsp_data,
    output logic                        nl_req,
    output logic                        nl_we,
    output logic [ADDR_W-1:0]           nl_addr,
    output logic [LINE_W-1:0]           nl_wdata,
    input  logic                        nl_ack,
    input  logic [LINE_W-1:0]           nl_rdata,
    output logic                        busy,
    output logic [CNT_W-1:0]            perf_hits,
    output logic [CNT_W-1:0]            perf_misses,
    output logic [CNT_W-1:0]            perf_writebacks
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int REPL  = LINE_W / ADDR_W;
    localparam int CD_W  = $clog2(HIT_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIT_WAIT,
        S_NL_WAIT,
        S_RESP
    } state_t;

    state_t state_reg, state_next;

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  owner_reg;
    logic              we_reg;
    logic [CD_W-1:0]   cd_reg;
    logic [LINE_W-1:0] data_reg;
    logic              nl_req_reg;
    logic              nl_we_reg;
    logic [ADDR_W-1:0] nl_addr_reg;
    logic [LINE_W-1:0] nl_wdata_reg;
    logic [CNT_W-1:0]  hits_reg;
    logic [CNT_W-1:0]  misses_reg;
    logic [CNT_W-1:0]  wb_reg;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  cand;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic [LINE_W-1:0] addr_line;
    logic [LINE_W-1:0] hit_line;

    // First valid port at or after the round-robin pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + i) % NUM_PORTS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state_reg == S_IDLE) && grant_found;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_idx == PTR_W'(p)) begin
                sel_we    = req_we[p];
                sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[p*LINE_W +: LINE_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < REPL; gi++) begin : g_repl
            assign addr_line[gi*ADDR_W +: ADDR_W] = sel_addr;
        end
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign req_ready[gi] = accept && (grant_idx == PTR_W'(gi));
            assign rsp_valid[gi] = (state_reg == S_RESP) && (owner_reg == PTR_W'(gi));
        end
    endgenerate

    assign hit_line = sel_we ? sel_wdata : addr_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != S_IDLE);
        rsp_data   = '0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = (MODE == 0) ? S_HIT_WAIT : S_NL_WAIT;
                end
            end
            S_HIT_WAIT: begin
                if (cd_reg == '0) begin
                    state_next = S_RESP;
                end
            end
            S_NL_WAIT: begin
                if (nl_ack) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_data   = data_reg;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            we_reg       <= 1'b0;
            cd_reg       <= '0;
            data_reg     <= '0;
            nl_req_reg   <= 1'b0;
            nl_we_reg    <= 1'b0;
            nl_addr_reg  <= '0;
            nl_wdata_reg <= '0;
            hits_reg     <= '0;
            misses_reg   <= '0;
            wb_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        rr_ptr_reg <= PTR_W'((int'(grant_idx) + 1) % NUM_PORTS);
                        owner_reg  <= grant_idx;
                        we_reg     <= sel_we;
                        cd_reg     <= CD_W'(HIT_LATENCY - 2);
                        data_reg   <= hit_line;
                        // The next-level request is only ever raised in forwarding mode.
                        if (MODE != 0) begin
                            nl_req_reg   <= 1'b1;
                            nl_we_reg    <= sel_we;
                            nl_addr_reg  <= sel_addr;
                            nl_wdata_reg <= sel_wdata;
                        end
                    end
                end
                S_HIT_WAIT: begin
                    if (cd_reg != '0) begin
                        cd_reg <= cd_reg - 1'b1;
                    end
                end
                S_NL_WAIT: begin
                    if (nl_ack) begin
                        nl_req_reg <= 1'b0;
                        data_reg   <= nl_we_reg ? nl_wdata_reg : nl_rdata;
                    end
                end
                S_RESP: begin
                    if (MODE == 0) begin
                        if (hits_reg != '1) hits_reg <= hits_reg + 1'b1;
                    end else begin
                        if (misses_reg != '1) misses_reg <= misses_reg + 1'b1;
                        if (we_reg && (wb_reg != '1)) wb_reg <= wb_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign nl_req          = nl_req_reg;
    assign nl_we           = nl_we_reg;
    assign nl_addr         = nl_addr_reg;
    assign nl_wdata        = nl_wdata_reg;
    assign perf_hits       = hits_reg;
    assign perf_misses     = misses_reg;
    assign perf_writebacks = wb_reg;

endmodule
